// File: rtl/ddr3_avl_arbiter_if.sv
// Bundle between the display read engine, the frame write engine, the arbiter and
// the DDR3 controller's Avalon slave. The arbiter uses master; the environment uses slave.
interface ddr3_avl_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 26
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_urgent;
    logic              rd_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              ddr3_avl_ready;
    logic              ddr3_avl_burstbegin;
    logic              ddr3_avl_read_req;
    logic              ddr3_avl_write_req;
    logic [ADDR_W-1:0] ddr3_avl_addr;
    logic [DATA_W-1:0] ddr3_avl_wdata;
    logic [2:0]        ddr3_avl_size;
    logic [15:0]       rd_cmd_count;
    logic [15:0]       wr_burst_count;

    modport master (
        input  rd_req, rd_addr, rd_urgent, wr_req, wr_addr, wr_data, ddr3_avl_ready,
        output rd_ready, wr_ready, ddr3_avl_burstbegin, ddr3_avl_read_req,
               ddr3_avl_write_req, ddr3_avl_addr, ddr3_avl_wdata, ddr3_avl_size,
               rd_cmd_count, wr_burst_count
    );

    modport slave (
        output rd_req, rd_addr, rd_urgent, wr_req, wr_addr, wr_data, ddr3_avl_ready,
        input  rd_ready, wr_ready, ddr3_avl_burstbegin, ddr3_avl_read_req,
               ddr3_avl_write_req, ddr3_avl_addr, ddr3_avl_wdata, ddr3_avl_size,
               rd_cmd_count, wr_burst_count
    );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// Round-robin-per-burst arbiter sharing one DDR3 Avalon port between a read engine
// and a write engine. state | meaning: IDLE | no grant; GNT_RD | read granted; GNT_WR | write burst in progress
module ddr3_avl_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 26
) (
    input logic                ddr3_clk,
    input logic                ddr3_reset_n,
    ddr3_avl_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR} state_t;

    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    state_t            state, state_nxt;
    logic              last_gnt, last_gnt_nxt;
    logic [2:0]        beat_cnt, beat_cnt_nxt;
    logic [ADDR_W-1:0] addr_lat, addr_lat_nxt;
    logic [15:0]       rd_cnt, rd_cnt_nxt;
    logic [15:0]       wr_cnt, wr_cnt_nxt;

    // last selects who gave way last time; urgency always wins for the read side
    function automatic state_t arbitrate(input logic rq, input logic ru,
                                         input logic wq, input logic last);
        state_t r;
        r = IDLE;
        if (rq && ru)      r = GNT_RD;
        else if (rq && wq) r = last ? GNT_RD : GNT_WR;
        else if (rq)       r = GNT_RD;
        else if (wq)       r = GNT_WR;
        return r;
    endfunction

    always_ff @(posedge ddr3_clk) begin
        if (!ddr3_reset_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            beat_cnt <= '0;
            addr_lat <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
            addr_lat <= addr_lat_nxt;
            rd_cnt   <= rd_cnt_nxt;
            wr_cnt   <= wr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        beat_cnt_nxt = beat_cnt;
        addr_lat_nxt = addr_lat;
        rd_cnt_nxt   = rd_cnt;
        wr_cnt_nxt   = wr_cnt;

        bus.rd_ready            = 1'b0;
        bus.wr_ready            = 1'b0;
        bus.ddr3_avl_burstbegin = 1'b0;
        bus.ddr3_avl_read_req   = 1'b0;
        bus.ddr3_avl_write_req  = 1'b0;
        bus.ddr3_avl_addr       = '0;
        bus.ddr3_avl_wdata      = '0;

        case (state)
            IDLE: begin
                state_nxt = arbitrate(bus.rd_req, bus.rd_urgent, bus.wr_req, last_gnt);
            end
            GNT_RD: begin
                // Gated by rd_req so a grant left over from re-arbitration never
                // issues a command once the engine has withdrawn its request.
                bus.ddr3_avl_read_req   = bus.rd_req;
                bus.ddr3_avl_burstbegin = bus.rd_req;
                bus.ddr3_avl_addr       = bus.rd_addr;
                bus.rd_ready            = bus.ddr3_avl_ready;
                if (!bus.rd_req) begin
                    state_nxt = IDLE;
                end else if (bus.ddr3_avl_ready) begin
                    rd_cnt_nxt   = rd_cnt + 16'd1;
                    last_gnt_nxt = 1'b0;
                    state_nxt    = arbitrate(bus.rd_req, bus.rd_urgent, bus.wr_req, 1'b0);
                end
            end
            GNT_WR: begin
                bus.ddr3_avl_write_req  = bus.wr_req;
                bus.ddr3_avl_wdata      = bus.wr_data;
                bus.ddr3_avl_burstbegin = bus.wr_req && (beat_cnt == 3'd0);
                bus.ddr3_avl_addr       = (beat_cnt == 3'd0) ? bus.wr_addr : addr_lat;
                bus.wr_ready            = bus.ddr3_avl_ready;
                if (bus.wr_req && bus.ddr3_avl_ready) begin
                    if (beat_cnt == 3'd0) addr_lat_nxt = bus.wr_addr;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt = '0;
                        wr_cnt_nxt   = wr_cnt + 16'd1;
                        last_gnt_nxt = 1'b1;
                        state_nxt    = arbitrate(bus.rd_req, bus.rd_urgent, bus.wr_req, 1'b1);
                    end else begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                    end
                end else if (!bus.wr_req && beat_cnt == 3'd0) begin
                    // No beat issued yet, so the grant is released rather than held.
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ddr3_avl_size  = 3'(BURST_LEN);
    assign bus.rd_cmd_count   = rd_cnt;
    assign bus.wr_burst_count = wr_cnt;
endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed bench for ddr3_avl_arbiter: expected Avalon transfers are queued as stimulus
// is issued and popped by a monitor on every accepted command or beat.
module tb_ddr3_avl_arbiter;
    localparam int BL = 4;

    typedef struct packed {
        logic        is_wr;
        logic [25:0] addr;
        logic [63:0] data;
        logic        bb;
    } exp_t;

    logic ddr3_clk;
    logic ddr3_reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   xfer_cyc[$];

    ddr3_avl_arbiter_if #(.DATA_W(64), .ADDR_W(26)) bus ();

    ddr3_avl_arbiter #(.BURST_LEN(BL), .DATA_W(64), .ADDR_W(26)) dut (
        .ddr3_clk     (ddr3_clk),
        .ddr3_reset_n (ddr3_reset_n),
        .bus          (bus)
    );

    initial ddr3_clk = 1'b0;
    always #5 ddr3_clk = ~ddr3_clk;
    always @(posedge ddr3_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every transfer on the Avalon side must match the queue head.
    always @(negedge ddr3_clk) begin
        exp_t e;
        if (ddr3_reset_n && bus.ddr3_avl_ready &&
            (bus.ddr3_avl_read_req || bus.ddr3_avl_write_req)) begin
            xfer_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_xfer", {62'd0, bus.ddr3_avl_write_req, bus.ddr3_avl_read_req}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("xfer_kind", {62'd0, bus.ddr3_avl_write_req, bus.ddr3_avl_read_req},
                      {62'd0, e.is_wr, ~e.is_wr});
                check("xfer_addr", 64'(bus.ddr3_avl_addr), 64'(e.addr));
                check("xfer_bb", 64'(bus.ddr3_avl_burstbegin), 64'(e.bb));
                if (e.is_wr) check("xfer_wdata", bus.ddr3_avl_wdata, e.data);
            end
        end
    end

    task automatic exp_rd(input logic [25:0] a);
        sb.push_back('{is_wr: 1'b0, addr: a, data: 64'd0, bb: 1'b1});
    endtask

    task automatic exp_wr(input logic [25:0] a, input logic [63:0] base);
        for (int b = 0; b < BL; b++)
            sb.push_back('{is_wr: 1'b1, addr: a, data: base + 64'(b), bb: (b == 0)});
    endtask

    task automatic do_read(input logic [25:0] a, output int lat);
        logic acc;
        lat = 0;
        acc = 1'b0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        while (!acc && lat < 200) begin
            @(negedge ddr3_clk);
            acc = bus.rd_ready;
            @(posedge ddr3_clk);
            #1;
            lat++;
        end
        check("rd_accept_timeout", 64'(acc), 64'd1);
        bus.rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [25:0] a, input logic [63:0] base,
                            input int gap_before, input int gap_len);
        logic acc;
        int   n;
        for (int b = 0; b < BL; b++) begin
            if (b == gap_before && gap_len > 0) begin
                bus.wr_req = 1'b0;
                repeat (gap_len) @(posedge ddr3_clk);
                #1;
            end
            bus.wr_req  = 1'b1;
            bus.wr_addr = (b == 0) ? a : (a ^ 26'h3FF);
            bus.wr_data = base + 64'(b);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                @(negedge ddr3_clk);
                acc = bus.wr_ready;
                @(posedge ddr3_clk);
                #1;
                n++;
            end
            check("wr_accept_timeout", 64'(acc), 64'd1);
        end
        bus.wr_req = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, {59'd0, bus.ddr3_avl_burstbegin, bus.ddr3_avl_read_req,
              bus.ddr3_avl_write_req, bus.rd_ready, bus.wr_ready}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        ddr3_reset_n      = 1'b0;
        bus.rd_req        = 1'b0;
        bus.rd_addr       = '0;
        bus.rd_urgent     = 1'b0;
        bus.wr_req        = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.ddr3_avl_ready = 1'b1;
        repeat (3) @(posedge ddr3_clk);
        #1;
        check_quiet("reset");
        check("reset_counts", {32'd0, bus.rd_cmd_count, bus.wr_burst_count}, 64'd0);
        check("size", 64'(bus.ddr3_avl_size), 64'(BL));
        ddr3_reset_n = 1'b1;
        repeat (2) @(posedge ddr3_clk);
        #1;

        // Single read: command visible one cycle after the request
        exp_rd(26'h100);
        do_read(26'h100, lat);
        check("rd_latency", 64'(lat), 64'd2);
        check("rd_cnt_1", 64'(bus.rd_cmd_count), 64'd1);
        repeat (3) @(posedge ddr3_clk);
        #1;
        check_quiet("idle_after_rd");

        // Write burst with ready toggling every cycle
        exp_wr(26'h200, 64'hA000);
        fork
            do_write(26'h200, 64'hA000, -1, 0);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(posedge ddr3_clk);
                    #1;
                    bus.ddr3_avl_ready = ~bus.ddr3_avl_ready;
                end
                bus.ddr3_avl_ready = 1'b1;
            end
        join
        repeat (2) @(posedge ddr3_clk);
        #1;
        check("wr_cnt_1", 64'(bus.wr_burst_count), 64'd1);
        check("sb_empty_t2", 64'(sb.size()), 64'd0);

        // Both continuously requesting: R W R W R W with no idle cycles
        xfer_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            exp_rd(26'h300 + 26'(16 * k));
            exp_wr(26'h400 + 26'(16 * k), 64'hB000 + 64'(16 * k));
        end
        fork
            for (int k = 0; k < 3; k++) begin
                int l;
                do_read(26'h300 + 26'(16 * k), l);
            end
            for (int k = 0; k < 3; k++)
                do_write(26'h400 + 26'(16 * k), 64'hB000 + 64'(16 * k), -1, 0);
        join
        repeat (3) @(posedge ddr3_clk);
        #1;
        check("alt_xfers", 64'(xfer_cyc.size()), 64'd15);
        if (xfer_cyc.size() == 15)
            check("alt_no_gaps", 64'(xfer_cyc[14] - xfer_cyc[0]), 64'd14);
        check("alt_counts", {32'd0, bus.rd_cmd_count, bus.wr_burst_count}, {32'd0, 16'd4, 16'd4});

        // Urgency during a write: burst completes, then read wins twice over a pending write
        exp_wr(26'h500, 64'hC000);
        exp_rd(26'h600);
        exp_rd(26'h610);
        exp_wr(26'h700, 64'hD000);
        fork
            begin
                do_write(26'h500, 64'hC000, -1, 0);
                do_write(26'h700, 64'hD000, -1, 0);
            end
            begin
                int l;
                repeat (2) @(posedge ddr3_clk);
                #1;
                bus.rd_urgent = 1'b1;
                do_read(26'h600, l);
                do_read(26'h610, l);
                bus.rd_urgent = 1'b0;
            end
        join
        repeat (3) @(posedge ddr3_clk);
        #1;
        check("urg_counts", {32'd0, bus.rd_cmd_count, bus.wr_burst_count}, {32'd0, 16'd6, 16'd6});

        // Write gap of 3 cycles before beat 2: grant held, pending read waits
        exp_wr(26'h800, 64'hE000);
        exp_rd(26'h900);
        fork
            do_write(26'h800, 64'hE000, 2, 3);
            begin
                int l;
                repeat (3) @(posedge ddr3_clk);
                #1;
                bus.rd_req  = 1'b1;
                bus.rd_addr = 26'h900;
                for (int g = 0; g < 3; g++) begin
                    @(negedge ddr3_clk);
                    check("gap_no_req", {62'd0, bus.ddr3_avl_read_req, bus.ddr3_avl_write_req}, 64'd0);
                    check("gap_wr_held", 64'(bus.wr_ready), 64'd1);
                end
                do_read(26'h900, l);
            end
        join
        repeat (3) @(posedge ddr3_clk);
        #1;
        check("gap_counts", {32'd0, bus.rd_cmd_count, bus.wr_burst_count}, {32'd0, 16'd7, 16'd7});

        // Reset during beat 1: only beat 0 reaches the controller
        sb.push_back('{is_wr: 1'b1, addr: 26'hA00, data: 64'hF000, bb: 1'b1});
        bus.wr_req  = 1'b1;
        bus.wr_addr = 26'hA00;
        bus.wr_data = 64'hF000;
        @(posedge ddr3_clk);
        #1;
        @(posedge ddr3_clk);
        #1;
        bus.wr_addr  = 26'hA00 ^ 26'h3FF;
        bus.wr_data  = 64'hF001;
        ddr3_reset_n = 1'b0;
        @(posedge ddr3_clk);
        #1;
        check_quiet("rst_mid_burst");
        check("rst_counts", {32'd0, bus.rd_cmd_count, bus.wr_burst_count}, 64'd0);
        @(posedge ddr3_clk);
        #1;
        check_quiet("rst_held");
        bus.wr_req   = 1'b0;
        ddr3_reset_n = 1'b1;
        repeat (2) @(posedge ddr3_clk);
        #1;
        check_quiet("post_rst");
        check("post_rst_bus", {bus.ddr3_avl_wdata[37:0], bus.ddr3_avl_addr}, 64'd0);
        check("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
